// File: rtl/paraleloserie.sv
// paraleloserie: byte-to-serial PCIe lane transmitter with a post-reset IDLE_SYM sync burst.
// Define PARALELOSERIE_LSB_FIRST_EN to send every symbol LSB first instead of MSB first.
module paraleloserie #(
  parameter logic [7:0]  IDLE_SYM     = 8'hBC,
  parameter int unsigned SYNC_SYMBOLS = 4
) (
  input  logic       clk32f,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       valid,
  output logic       ready,
  output logic       out,
  output logic       active
);

  typedef enum logic {SYNC = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_SYMBOLS - 1);

  state_t      state_r, next_state_s;
  logic [7:0]  sr_r, next_sr_s;
  logic [2:0]  bit_cnt_r;
  logic [3:0]  sync_cnt_r, next_sync_s;
  logic        boundary_s;
  logic        ready_next_s;

  // The shifter always emits sr[7]; bit order is chosen once, when a symbol is loaded.
  function automatic logic [7:0] order_sym(input logic [7:0] sym);
`ifdef PARALELOSERIE_LSB_FIRST_EN
    logic [7:0] rev;
    for (int i = 0; i < 8; i++) begin
      rev[i] = sym[7-i];
    end
    return rev;
`else
    return sym;
`endif
  endfunction

  // Next-state, shift/reload and look-ahead ready decode.
  always_comb begin
    boundary_s   = (bit_cnt_r == 3'd7);
    next_state_s = state_r;
    next_sync_s  = sync_cnt_r;
    next_sr_s    = {sr_r[6:0], 1'b0};
    ready_next_s = 1'b0;
    if (boundary_s) begin
      if (ready && valid) begin
        next_sr_s = order_sym(in);
      end else begin
        next_sr_s = order_sym(IDLE_SYM);
      end
      case (state_r)
        SYNC: begin
          next_sync_s = sync_cnt_r + 4'd1;
          if (sync_cnt_r == SYNC_LAST) begin
            next_state_s = ACTIVE;
          end else begin
            next_state_s = SYNC;
          end
        end
        ACTIVE:  next_state_s = ACTIVE;
        default: next_state_s = SYNC;
      endcase
    end else begin
      // ready is registered one cycle early; state and sync_cnt cannot change off-boundary
      if (bit_cnt_r == 3'd6) begin
        ready_next_s = (state_r == ACTIVE) || (sync_cnt_r == SYNC_LAST);
      end else begin
        ready_next_s = 1'b0;
      end
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk32f) begin
    if (reset) begin
      state_r    <= SYNC;
      bit_cnt_r  <= 3'd0;
      sync_cnt_r <= 4'd0;
      sr_r       <= order_sym(IDLE_SYM);
      out        <= 1'b0;
      active     <= 1'b0;
      ready      <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      bit_cnt_r  <= bit_cnt_r + 3'd1;
      sync_cnt_r <= next_sync_s;
      sr_r       <= next_sr_s;
      out        <= sr_r[7];
      active     <= (next_state_s == ACTIVE);
      ready      <= ready_next_s;
    end
  end

endmodule

// File: tb/tb_paraleloserie.sv
// Self-checking bench for paraleloserie: a slot-based reference model predicts out/ready/active.
// Honours PARALELOSERIE_LSB_FIRST_EN when the design is built with it.
module tb_paraleloserie;

  localparam logic [7:0] IDLE = 8'hBC;
  localparam int         SYNC = 4;

  logic       clk32f = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] din    = 8'h00;
  logic       valid  = 1'b0;
  logic       ready;
  logic       out;
  logic       active;

  int         n;
  bit         hs;
  logic [7:0] slot [int];
  int         pass_cnt  = 0;
  int         total_cnt = 0;

  paraleloserie #(.IDLE_SYM(IDLE), .SYNC_SYMBOLS(SYNC)) dut (
    .clk32f(clk32f),
    .reset (reset),
    .in    (din),
    .valid (valid),
    .ready (ready),
    .out   (out),
    .active(active)
  );

  always #5 clk32f = ~clk32f;

  // Symbol occupying slot k (edges 8k+1..8k+8 after reset release).
  function automatic logic [7:0] sym_at(int k);
    if (k < SYNC) return IDLE;
    if (slot.exists(k)) return slot[k];
    return IDLE;
  endfunction

  function automatic logic exp_out();
    logic [7:0] s;
    int b;
    if (n == 0) return 1'b0;
    s = sym_at((n - 1) / 8);
    b = (n - 1) % 8;
`ifdef PARALELOSERIE_LSB_FIRST_EN
    return s[b];
`else
    return s[7-b];
`endif
  endfunction

  function automatic logic exp_ready();
    return (((n + 1) % 8) == 0) && (((n + 1) / 8) >= SYNC);
  endfunction

  function automatic logic exp_active();
    return n >= 8 * SYNC;
  endfunction

  // Byte as it appears when serial bits are collected first-bit-as-MSB.
  function automatic logic [7:0] ord(input logic [7:0] b);
`ifdef PARALELOSERIE_LSB_FIRST_EN
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
`else
    return b;
`endif
  endfunction

  // One clock edge: advance the model with the inputs seen at that edge, then sample #1 later.
  task automatic tick();
    @(posedge clk32f);
    hs = 1'b0;
    if (reset) begin
      n = 0;
      slot.delete();
    end else begin
      n++;
      if ((n % 8) == 0 && (n / 8) >= SYNC && valid) begin
        slot[n / 8] = din;
        hs = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid = 1'b0; din = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if (out !== 1'b0) $display("FAIL reset_out: got %b want 0", out); else pass_cnt++;
      total_cnt++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready); else pass_cnt++;
      total_cnt++; if (active !== 1'b0) $display("FAIL reset_active: got %b want 0", active); else pass_cnt++;
    end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      total_cnt++; if (out !== exp_out()) $display("FAIL sync_out edge %0d: got %b want %b", n, out, exp_out()); else pass_cnt++;
      total_cnt++; if (ready !== exp_ready()) $display("FAIL sync_ready edge %0d: got %b want %b", n, ready, exp_ready()); else pass_cnt++;
      total_cnt++; if (active !== exp_active()) $display("FAIL sync_active edge %0d: got %b want %b", n, active, exp_active()); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes [3];
    logic [23:0] got, want;
    int idx, cyc, nbits;
    bit collecting;
    bytes = '{8'hA5, 8'h3C, 8'hFF};
    want = {ord(8'hA5), ord(8'h3C), ord(8'hFF)};
    idx = 0; cyc = 0; nbits = 0; got = 24'h0; collecting = 1'b0;
    valid = 1'b1; din = bytes[0];
    while ((idx < 3 || nbits < 24) && cyc < 100) begin
      tick(); cyc++;
      if (collecting && nbits < 24) begin got = {got[22:0], out}; nbits++; end
      if (hs) begin
        collecting = 1'b1; idx++;
        if (idx < 3) din = bytes[idx]; else valid = 1'b0;
      end
      total_cnt++; if (out !== exp_out()) $display("FAIL b2b_out edge %0d: got %b want %b", n, out, exp_out()); else pass_cnt++;
      total_cnt++; if (ready !== exp_ready()) $display("FAIL b2b_ready edge %0d: got %b want %b", n, ready, exp_ready()); else pass_cnt++;
    end
    valid = 1'b0;
    total_cnt++; if (cyc >= 100) $display("FAIL b2b_timeout: got %0d cycles want <100", cyc); else pass_cnt++;
    total_cnt++; if (got !== want) $display("FAIL b2b_stream: got %h want %h", got, want); else pass_cnt++;
  endtask

  task automatic test_mid_symbol();
    logic [12:0] got, want;
    logic [7:0]  idle_o;
    int cyc, nbits;
    idle_o = ord(IDLE);
    want = {idle_o[4:0], ord(8'h55)};
    valid = 1'b0;
    for (int g = 0; g < 16 && (n % 8) != 3; g++) tick();
    valid = 1'b1; din = 8'h55;
    cyc = 0; nbits = 0; got = 13'h0;
    while (nbits < 13 && cyc < 40) begin
      tick(); cyc++;
      got = {got[11:0], out}; nbits++;
      if (hs) valid = 1'b0;
      total_cnt++; if (out !== exp_out()) $display("FAIL mid_out edge %0d: got %b want %b", n, out, exp_out()); else pass_cnt++;
      total_cnt++; if (ready !== exp_ready()) $display("FAIL mid_ready edge %0d: got %b want %b", n, ready, exp_ready()); else pass_cnt++;
    end
    valid = 1'b0;
    total_cnt++; if (got !== want) $display("FAIL mid_stream: got %b want %b", got, want); else pass_cnt++;
  endtask

  task automatic test_gap();
    logic [23:0] got, want;
    int phase, cyc, nbits, wait_cnt;
    want = {ord(8'h81), ord(IDLE), ord(8'h7E)};
    phase = 0; cyc = 0; nbits = 0; wait_cnt = 0; got = 24'h0;
    valid = 1'b1; din = 8'h81;
    while (nbits < 24 && cyc < 100) begin
      tick(); cyc++;
      if (phase > 0) begin got = {got[22:0], out}; nbits++; end
      case (phase)
        0: if (hs) begin phase = 1; valid = 1'b0; end
        1: begin wait_cnt++; if (wait_cnt == 8) begin phase = 2; valid = 1'b1; din = 8'h7E; end end
        2: if (hs) begin phase = 3; valid = 1'b0; end
        default: valid = 1'b0;
      endcase
      total_cnt++; if (out !== exp_out()) $display("FAIL gap_out edge %0d: got %b want %b", n, out, exp_out()); else pass_cnt++;
    end
    valid = 1'b0;
    total_cnt++; if (got !== want) $display("FAIL gap_stream: got %h want %h", got, want); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    cyc = 0;
    valid = 1'b1; din = 8'hA5;
    while (!hs && cyc < 20) begin tick(); cyc++; end
    valid = 1'b0;
    total_cnt++; if (!hs) $display("FAIL rmid_handshake: got none want one within 20 cycles"); else pass_cnt++;
    for (int g = 0; g < 16 && (n % 8) != 4; g++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++; if (out !== 1'b0) $display("FAIL rmid_out: got %b want 0", out); else pass_cnt++;
    total_cnt++; if (active !== 1'b0) $display("FAIL rmid_active: got %b want 0", active); else pass_cnt++;
    for (int i = 0; i < 40; i++) begin
      tick();
      total_cnt++; if (out !== exp_out()) $display("FAIL rmid_out edge %0d: got %b want %b", n, out, exp_out()); else pass_cnt++;
      total_cnt++; if (ready !== exp_ready()) $display("FAIL rmid_ready edge %0d: got %b want %b", n, ready, exp_ready()); else pass_cnt++;
      total_cnt++; if (active !== exp_active()) $display("FAIL rmid_active edge %0d: got %b want %b", n, active, exp_active()); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      valid = ($urandom_range(0, 1) == 1);
      din   = 8'($urandom_range(0, 255));
      reset = ($urandom_range(0, 249) == 0);
      tick();
      total_cnt++; if (out !== exp_out()) $display("FAIL rand_out edge %0d: got %b want %b", n, out, exp_out()); else pass_cnt++;
      total_cnt++; if (ready !== exp_ready()) $display("FAIL rand_ready edge %0d: got %b want %b", n, ready, exp_ready()); else pass_cnt++;
      total_cnt++; if (active !== exp_active()) $display("FAIL rand_active edge %0d: got %b want %b", n, active, exp_active()); else pass_cnt++;
    end
    reset = 1'b0; valid = 1'b0;
  endtask

  initial begin
    n = 0;
    hs = 1'b0;
    test_reset();
    test_back_to_back();
    test_mid_symbol();
    test_gap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
